// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit path.
// Optional even-parity PAR slot is selected with SERIAL_TX_ARB_PARITY_EN.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        GAP
    } tx_state_e;

    localparam int   SER_DATA_BITS = 7;
    localparam logic SER_START_BIT = 1'b0;
    localparam logic SER_STOP_BIT  = 1'b1;

    // Value carried in the PAR slot: even parity over the 7 data bits,
    // or the raw eighth data bit when parity is not built in.
    function automatic logic parSlot(input logic [7:0] b);
`ifdef SERIAL_TX_ARB_PARITY_EN
        return ^b[6:0];
`else
        return b[7];
`endif
    endfunction

endpackage

// File: rtl/serial_tx_framer.sv
// Framing sequencer: start bit, 7 data bits LSB first, PAR slot, stop bit,
// then IDLE_GAP idle-high cycles. The tx register is loaded with the value
// belonging to the next state so the line never glitches.
// PAR slot content depends on SERIAL_TX_ARB_PARITY_EN (see serial_pkg).
module serial_tx_framer
    import serial_pkg::*;
#(
    parameter int IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       idle_o,
    output logic       frame_done_o
);

    localparam logic [2:0] LAST_BIT = 3'(SER_DATA_BITS - 1);
    localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;

    // State, datapath and line register; reset forces the line idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= SER_STOP_BIT;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
        end
    end

    // Next-state logic; tx_d is the line value for the state being entered.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        par_d     = par_q;
        tx_d      = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = SER_STOP_BIT;
                if (load_i) begin
                    state_d = START;
                    shift_d = data_i;
                    par_d   = parSlot(data_i);
                    tx_d    = SER_START_BIT;
                end
            end
            START: begin
                state_d   = DATA;
                tx_d      = shift_q[0];
                shift_d   = {1'b0, shift_q[7:1]};
                bit_cnt_d = '0;
            end
            DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = PAR;
                    tx_d    = par_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                end
            end
            PAR: begin
                state_d = STOP;
                tx_d    = SER_STOP_BIT;
            end
            STOP: begin
                tx_d      = SER_STOP_BIT;
                gap_cnt_d = '0;
                state_d   = (IDLE_GAP > 0) ? GAP : IDLE;
            end
            GAP: begin
                tx_d = SER_STOP_BIT;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = SER_STOP_BIT;
            end
        endcase
    end

    assign tx_o         = tx_q;
    assign idle_o       = (state_q == IDLE);
    assign frame_done_o = (state_q == STOP);

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial transmit line among N_REQ byte
// requesters. Build option SERIAL_TX_ARB_PARITY_EN selects even parity in
// the PAR slot instead of the raw eighth data bit.
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int IDLE_GAP = 1,
    localparam int GW       = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx,
    output logic               busy,
    output logic [GW-1:0]      grant_id,
    output logic               frame_done
);

    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [GW-1:0] pick;
    logic [GW:0]   cand;
    logic          found;
    logic [7:0]    selData;
    logic          idle;
    logic          load;

    // Search from rr_ptr upward with wrap for the first valid requester,
    // then mux out that requester's byte.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        cand    = '0;
        selData = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (GW + 1)'(i);
            if (cand >= (GW + 1)'(N_REQ)) begin
                cand = cand - (GW + 1)'(N_REQ);
            end
            if (!found && req_valid[cand[GW-1:0]]) begin
                found = 1'b1;
                pick  = cand[GW-1:0];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == GW'(i)) begin
                selData = req_data[i*8 +: 8];
            end
        end
    end

    assign load      = idle && found;
    assign req_ready = load ? (N_REQ'(1) << pick) : '0;

    // On accept, remember the winner and move priority just past it.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        if (load) begin
            grant_id_d = pick;
            rr_ptr_d   = (pick == GW'(N_REQ - 1)) ? '0 : pick + GW'(1);
        end
    end

    // Arbiter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

    serial_tx_framer #(
        .IDLE_GAP(IDLE_GAP)
    ) u_framer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .data_i      (selData),
        .tx_o        (tx),
        .idle_o      (idle),
        .frame_done_o(frame_done)
    );

    assign busy     = !idle;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: scoreboard of expected grants/bytes, frame
// bit sequences checked cycle by cycle, plus an IDLE_GAP=0 instance.
module tb_serial_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   reqValid, reqValid2;
    logic [8*N-1:0] reqData, reqData2;
    logic [N-1:0]   reqReady, reqReady2;
    logic           tx, tx2, busy, busy2, frameDone, frameDone2;
    logic [1:0]     grantId, grantId2;

    int cycle = 0;
    int vectors = 0;
    int miscompares = 0;
    int lastAccept = -1;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    serial_tx_arbiter #(.N_REQ(N), .IDLE_GAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_data(reqData),
        .req_ready(reqReady), .tx(tx), .busy(busy), .grant_id(grantId),
        .frame_done(frameDone)
    );

    serial_tx_arbiter #(.N_REQ(N), .IDLE_GAP(0)) dutNoGap (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValid2), .req_data(reqData2),
        .req_ready(reqReady2), .tx(tx2), .busy(busy2), .grant_id(grantId2),
        .frame_done(frameDone2)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure accept spacing.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive a request and record the grant/byte it should produce.
    task automatic applyStimulus(input int id, input logic [7:0] d);
        exp_t e;
        reqData[id*8 +: 8] = d;
        reqValid[id] = 1'b1;
        e.id = id;
        e.data = d;
        sb.push_back(e);
    endtask

    // Line sequence for cycles T+1..T+10 of a frame carrying byte d.
    function automatic logic [9:0] frameBits(input logic [7:0] d);
        logic [9:0] b;
        b[0] = 1'b0;
        for (int i = 0; i < 7; i++) b[i+1] = d[i];
`ifdef SERIAL_TX_ARB_PARITY_EN
        b[8] = ^d[6:0];
`else
        b[8] = d[7];
`endif
        b[9] = 1'b1;
        return b;
    endfunction

    // Wait for an accept, compare with the scoreboard, then follow nBits
    // cycles of the frame.
    task automatic runFrame(input bit dropAfter, input int spacing, input int nBits);
        exp_t e;
        logic [9:0] bits;
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (reqReady != '0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            checkOutput("scoreboardEmpty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        checkOutput($sformatf("readyOneHot_id%0d", e.id), reqReady, 32'd1 << e.id);
        checkOutput("txAcceptCycle", tx, 1);
        if (spacing > 0 && lastAccept >= 0)
            checkOutput("acceptSpacing", cycle - lastAccept, spacing);
        lastAccept = cycle;
        bits = frameBits(e.data);
        for (int t = 1; t <= nBits; t++) begin
            @(negedge clk);
            if (t == 1 && dropAfter) reqValid[e.id] = 1'b0;
            checkOutput($sformatf("tx_T%0d_id%0d", t, e.id), tx, bits[t-1]);
            checkOutput($sformatf("frameDone_T%0d", t), frameDone, (t == 10));
            if (t == 1) begin
                checkOutput("grantId", grantId, e.id);
                checkOutput("busyRise", busy, 1);
                checkOutput("readyDropped", reqReady, 0);
            end
        end
    endtask

    initial begin
        int c0;
        bit seen;
        rst_n = 1'b0;
        reqValid = '0;
        reqData = '0;
        reqValid2 = '0;
        reqData2 = '0;
        repeat (2) @(negedge clk);
        checkOutput("resetTx", tx, 1);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetReady", reqReady, 0);
        checkOutput("resetFrameDone", frameDone, 0);
        checkOutput("resetGrant", grantId, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single request, requester 2 byte C1");
        applyStimulus(2, 8'hC1);
        runFrame(1'b1, 0, 10);
        @(negedge clk);
        checkOutput("gapTx", tx, 1);
        checkOutput("gapBusy", busy, 1);
        @(negedge clk);
        checkOutput("idleBusy", busy, 0);
        checkOutput("grantHold", grantId, 2);

        $display("[TB] requester 1 byte 07");
        applyStimulus(1, 8'h07);
        runFrame(1'b1, 0, 10);

        $display("[TB] all four valid from reset");
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(0, 8'h5A);
        applyStimulus(1, 8'h3C);
        applyStimulus(2, 8'hFF);
        applyStimulus(3, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        lastAccept = -1;
        for (int f = 0; f < 4; f++) runFrame(1'b0, 12, 10);
        reqValid = '0;

        $display("[TB] requesters 0 and 2 continuous");
        applyStimulus(0, 8'h96);
        applyStimulus(2, 8'h69);
        applyStimulus(0, 8'h96);
        applyStimulus(2, 8'h69);
        lastAccept = -1;
        for (int f = 0; f < 4; f++) runFrame(1'b0, 12, 10);
        reqValid = '0;

        $display("[TB] reset during data bit 3");
        applyStimulus(1, 8'hB5);
        runFrame(1'b1, 0, 5);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midResetTx", tx, 1);
        checkOutput("midResetBusy", busy, 0);
        checkOutput("midResetFrameDone", frameDone, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("heldResetFrameDone", frameDone, 0);
        end
        rst_n = 1'b1;
        applyStimulus(0, 8'h24);
        applyStimulus(2, 8'h42);
        runFrame(1'b1, 0, 10);
        runFrame(1'b1, 0, 10);

        $display("[TB] IDLE_GAP=0 continuous requester 1");
        @(negedge clk);
        reqData2[15:8] = 8'h55;
        reqValid2[1] = 1'b1;
        seen = 1'b0;
        c0 = 0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (reqReady2 != '0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checkOutput("noGapAcceptTimeout", 32'd0, 32'd1);
        end else begin
            c0 = cycle;
            checkOutput("noGapReady", reqReady2, 4'b0010);
            for (int t = 1; t <= 10; t++) @(negedge clk);
            checkOutput("noGapStopTx", tx2, 1);
            checkOutput("noGapFrameDone", frameDone2, 1);
            @(negedge clk);
            #1;
            checkOutput("noGapReadyAgain", reqReady2, 4'b0010);
            checkOutput("noGapAcceptTx", tx2, 1);
            checkOutput("noGapAcceptBusy", busy2, 0);
            checkOutput("noGapPeriod", cycle - c0, 11);
        end
        reqValid2 = '0;

        checkOutput("scoreboardDrained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
